// File: rtl/gate_exerciser.sv
// Truth-table exerciser for a two-input gate: drives A/B through 00..11,
// samples the gate output after a settle window and counts mismatches.
module gate_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2,  // 1..15
  parameter int unsigned PASSES        = 1   // 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  localparam logic [3:0] CntLoad  = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LastPass = 4'(PASSES - 1);

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] pidx_q, pidx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       exp_y;

  // Expected gate output for the vector currently on the pins.
  always_comb begin
    exp_y = vec_q[1] | vec_q[0];
    case (sel_q)
      3'd0:    exp_y = vec_q[1] & vec_q[0];
      3'd1:    exp_y = vec_q[1] | vec_q[0];
      3'd2:    exp_y = ~(vec_q[1] & vec_q[0]);
      3'd3:    exp_y = ~(vec_q[1] | vec_q[0]);
      3'd4:    exp_y = vec_q[1] ^ vec_q[0];
      3'd5:    exp_y = ~(vec_q[1] ^ vec_q[0]);
      default: exp_y = vec_q[1] | vec_q[0];  // 6 and 7 behave as OR
    endcase
  end

  // Next-state logic for the sweep controller and result registers.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    pidx_d  = pidx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sel_d   = gate_sel;
          vec_d   = 2'd0;
          pidx_d  = 4'd0;
          err_d   = 8'd0;
          pass_d  = 1'b0;
          cnt_d   = CntLoad;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSample: begin
        if ((y_in != exp_y) && (err_q != 8'hff)) begin
          err_d = err_q + 8'd1;
        end
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = CntLoad;
          state_d = StSettle;
        end else if (pidx_q != LastPass) begin
          pidx_d  = pidx_q + 4'd1;
          vec_d   = 2'd0;
          cnt_d   = CntLoad;
          state_d = StSettle;
        end else begin
          // Verdict includes the sample taken on this very edge.
          vec_d   = 2'd0;
          pass_d  = (err_d == 8'd0);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset aborts any run without reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= 3'd0;
      vec_q   <= 2'd0;
      pidx_q  <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 8'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
      pidx_q  <= pidx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign a_out     = vec_q[1];
  assign b_out     = vec_q[0];
  assign busy      = (state_q == StSettle) || (state_q == StSample);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Self-checking bench: two exerciser instances (different settle/pass counts)
// driving a modelled gate whose truth table the bench chooses per run.
module tb_gate_exerciser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] gate_sel = 3'd0;
  logic [3:0] model_tt = 4'b1110;  // gate under test: bit v is Y for {A,B}=v
  logic       which = 1'b0;        // 0 selects dut1, 1 selects dut3

  logic a1, b1, busy1, done1, pass1;
  logic a3, b3, busy3, done3, pass3;
  logic [7:0] err1, err3;
  logic y1, y3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign y1 = model_tt[{a1, b1}];
  assign y3 = model_tt[{a3, b3}];

  gate_exerciser #(.SETTLE_CYCLES(2), .PASSES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & ~which), .gate_sel(gate_sel), .y_in(y1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
  );

  gate_exerciser #(.SETTLE_CYCLES(1), .PASSES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start & which), .gate_sel(gate_sel), .y_in(y3),
    .a_out(a3), .b_out(b3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3)
  );

  logic       a_w, b_w, busy_w, done_w, pass_w;
  logic [7:0] err_w;
  assign a_w    = which ? a3 : a1;
  assign b_w    = which ? b3 : b1;
  assign busy_w = which ? busy3 : busy1;
  assign done_w = which ? done3 : done1;
  assign pass_w = which ? pass3 : pass1;
  assign err_w  = which ? err3 : err1;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Truth table of the selected function, indexed by vector {A,B}.
  function automatic logic [3:0] sel_tt(input logic [2:0] sel);
    case (sel)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      default: return 4'b1110;
    endcase
  endfunction

  // One full run, checked every cycle against the sweep schedule.
  task automatic run_check(input logic [2:0] sel, input logic [3:0] mtt,
                           input logic [2:0] alt_sel, input int busy_pulse_k,
                           input bit done_pulse);
    int unsigned per, len, v, exp_err;
    logic [3:0] stt;
    per     = which ? 2 : 3;
    len     = (which ? 3 : 1) * 4 * per;
    stt     = sel_tt(sel);
    exp_err = 0;
    @(negedge clk);
    model_tt = mtt;
    gate_sel = sel;
    start    = 1'b1;
    @(posedge clk);
    for (int k = 0; k < int'(len); k++) begin
      @(negedge clk);
      start = (k == busy_pulse_k);
      if (k == int'(len / 2)) gate_sel = alt_sel;
      v = (int'(k) / per) % 4;
      check_eq("busy", busy_w, 1);
      check_eq("done_low", done_w, 0);
      check_eq("ab", {a_w, b_w}, v);
      check_eq("err_run", err_w, exp_err);
      check_eq("pass_run", pass_w, 0);
      if ((k % per) == (per - 1) && mtt[v] != stt[v] && exp_err < 255) exp_err++;
      @(posedge clk);
    end
    @(negedge clk);
    start = done_pulse;
    check_eq("done", done_w, 1);
    check_eq("busy_done", busy_w, 0);
    check_eq("ab_done", {a_w, b_w}, 0);
    check_eq("err_done", err_w, exp_err);
    check_eq("pass_done", pass_w, (exp_err == 0) ? 1 : 0);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("idle_done", done_w, 0);
      check_eq("idle_busy", busy_w, 0);
      check_eq("idle_err", err_w, exp_err);
      check_eq("idle_pass", pass_w, (exp_err == 0) ? 1 : 0);
      @(posedge clk);
    end
  endtask

  // Reset during the vector-10 settle window of dut1.
  task automatic abort_check();
    which    = 1'b0;
    model_tt = 4'b1110;
    @(negedge clk);
    gate_sel = 3'd1;
    start    = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    check_eq("pre_abort_ab", {a_w, b_w}, 2);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ab", {a_w, b_w}, 0);
    check_eq("abort_busy", busy_w, 0);
    check_eq("abort_done", done_w, 0);
    check_eq("abort_err", err_w, 0);
    check_eq("abort_pass", pass_w, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check_eq("post_abort_busy", busy_w, 0);
      check_eq("post_abort_done", done_w, 0);
    end
  endtask

  initial begin
    logic [2:0] s, alt;
    logic [3:0] m;
    repeat (2) @(negedge clk);
    check_eq("rst_ab", {a1, b1, a3, b3}, 0);
    check_eq("rst_busy", {busy1, busy3}, 0);
    check_eq("rst_done", {done1, done3}, 0);
    check_eq("rst_pass", {pass1, pass3}, 0);
    check_eq("rst_err", {err1, err3}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    which = 1'b0;
    run_check(3'd1, 4'b1110, 3'd1, -1, 1'b0);  // correct OR
    run_check(3'd1, 4'b0000, 3'd1, -1, 1'b0);  // stuck at 0: 3 errors
    which = 1'b1;
    run_check(3'd1, 4'b1111, 3'd1, -1, 1'b0);  // stuck at 1, 3 passes: 3 errors
    which = 1'b0;
    run_check(3'd4, 4'b0110, 3'd0, -1, 1'b0);  // XOR latched, sel changes to AND
    run_check(3'd7, 4'b1110, 3'd2, -1, 1'b0);  // code 7 acts as OR
    run_check(3'd1, 4'b1110, 3'd1, 4, 1'b1);   // start while busy and in DONE
    abort_check();
    run_check(3'd1, 4'b1110, 3'd1, -1, 1'b0);  // full run after abort

    for (int i = 0; i < 12; i++) begin
      which = 1'($urandom_range(0, 1));
      s     = 3'($urandom_range(0, 7));
      alt   = 3'($urandom_range(0, 7));
      m     = ($urandom_range(0, 1) == 0) ? sel_tt(s) : 4'($urandom_range(0, 15));
      run_check(s, m, alt, $urandom_range(0, 1) == 0 ? -1 : int'($urandom_range(0, 11)),
                1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
